// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline write-back and a 2-entry long-latency result queue
//   params : DATA_W (data width), STARVE_MAX (denied cycles tolerated by the queue head before a forced stall)
//   in     : clk, rst_n (async active-low), wb_we/wb_rd/wb_data (pipeline write-back), lu_valid/lu_rd/lu_data (long-latency result)
//   out    : lu_ready (queue can accept), rf_we/rf_rd/rf_wdata (register-file write port), pipe_stall (freeze whole pipeline)
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    input  logic [4:0]        lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);
    logic [4:0]        rd_q   [2];
    logic [DATA_W-1:0] data_q [2];
    logic              rptr, wptr;
    logic [1:0]        count;
    logic [CW-1:0]     cnt;
    logic              head, wb_eff, push, pop;
    assign head       = count != 2'd0;
    // ready looks only at registered occupancy, so a same-cycle pop never enables a push into a full queue
    assign lu_ready   = count != 2'd2;
    // results for x0 complete the handshake but are dropped here
    assign push       = lu_valid & lu_ready & (lu_rd != 5'd0);
    assign wb_eff     = wb_we & (wb_rd != 5'd0);
    assign pipe_stall = (cnt == CMAX) & head;
    // a stall steals the slot from the pipeline; otherwise the queue only gets idle slots
    assign pop        = head & (pipe_stall | ~wb_eff);
    assign rf_we      = rst_n & (wb_eff | head);
    assign rf_rd      = pop ? rd_q[rptr] : wb_rd;
    assign rf_wdata   = pop ? data_q[rptr] : wb_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
            cnt   <= '0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop) rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
            cnt   <= (!head || pop) ? '0 : (cnt == CMAX) ? cnt : cnt + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= lu_rd;
            data_q[wptr] <= lu_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for the write-back port arbiter
module tb_wb_port_arbiter;
    localparam int DW = 32;
    localparam int SM = 4;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_we = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          lu_valid = 1'b0;
    logic [4:0]    lu_rd = '0;
    logic [DW-1:0] lu_data = '0;
    logic          lu_ready, rf_we, pipe_stall;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wdata;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    wb_port_arbiter #(.DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
        .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    // every observed register-file write must match the next expected write, in order
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wr_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rf_rd, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({rf_rd, rf_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h", rf_rd, rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] rd, input logic [DW-1:0] d,
                         input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
        @(posedge clk);
        #1;
        wb_we = we; wb_rd = rd; wb_data = d;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
        n_cmp++;
        if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", pipe_stall); end
        n_cmp++;
        if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", lu_ready); end
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_release_we: got %b expected 0", rf_we); end
    endtask

    task automatic test_idle_push();
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL idle_no_bypass: got %b expected 0", rf_we); end
        drive(0, 0, 0, 0, 0, 0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1) begin n_bad++; $display("FAIL idle_write: got %b expected 1", rf_we); end
        n_cmp++;
        if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall: got %b expected 0", pipe_stall); end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL idle_after: got %b expected 0", rf_we); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL idle_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 7; i++) begin
            drive(1, 5'd3, 32'h11, i == 0, 5'd7, 32'hA7);
            if (i == SM + 1) exp_q.push_back({5'd7, 32'hA7});
            else exp_q.push_back({5'd3, 32'h11});
            @(negedge clk);
            n_cmp++;
            if (pipe_stall !== (i == SM + 1)) begin n_bad++; $display("FAIL starve_stall[%0d]: got %b expected %b", i, pipe_stall, i == SM + 1); end
            n_cmp++;
            if (rf_we !== 1'b1) begin n_bad++; $display("FAIL starve_we[%0d]: got %b expected 1", i, rf_we); end
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL starve_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]    lrd;
        logic [DW-1:0] ld;
        logic          st, rdy;
        for (int i = 0; i < 17; i++) begin
            lrd = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10;
            ld  = (i == 0) ? 32'h80 : (i == 1) ? 32'h90 : 32'hA0;
            drive(1, 5'd3, 32'h11, i <= 6, lrd, ld);
            if (i == 5) exp_q.push_back({5'd8, 32'h80});
            else if (i == 10) exp_q.push_back({5'd9, 32'h90});
            else if (i == 15) exp_q.push_back({5'd10, 32'hA0});
            else exp_q.push_back({5'd3, 32'h11});
            st  = (i == 5) || (i == 10) || (i == 15);
            rdy = !((i >= 2 && i <= 5) || (i >= 7 && i <= 10));
            @(negedge clk);
            n_cmp++;
            if (pipe_stall !== st) begin n_bad++; $display("FAIL b2b_stall[%0d]: got %b expected %b", i, pipe_stall, st); end
            n_cmp++;
            if (lu_ready !== rdy) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, lu_ready, rdy); end
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 5'd12, 32'hC0);
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_first: got %b expected 0", rf_we); end
        drive(1, 5'd0, 32'h55, 1, 5'd0, 32'hBAD);
        exp_q.push_back({5'd12, 32'hC0});
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1) begin n_bad++; $display("FAIL x0_head_we: got %b expected 1", rf_we); end
        n_cmp++;
        if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b expected 1", lu_ready); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 5'd0, 32'h55, 0, 0, 0);
            @(negedge clk);
            n_cmp++;
            if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_no_write[%0d]: got %b expected 0", i, rf_we); end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL x0_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_push_pop();
        drive(0, 0, 0, 1, 5'd13, 32'hD0);
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd14, 32'hE0);
        exp_q.push_back({5'd13, 32'hD0});
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1) begin n_bad++; $display("FAIL pp_pop_we: got %b expected 1", rf_we); end
        drive(1, 5'd3, 32'h22, 0, 0, 0);
        exp_q.push_back({5'd3, 32'h22});
        @(negedge clk);
        n_cmp++;
        if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL pp_count_one: got ready %b expected 1", lu_ready); end
        drive(0, 0, 0, 0, 0, 0);
        exp_q.push_back({5'd14, 32'hE0});
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b1) begin n_bad++; $display("FAIL pp_second_we: got %b expected 1", rf_we); end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL pp_empty: got %b expected 0", rf_we); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL pp_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd3, 32'h11, i <= 1, (i == 0) ? 5'd15 : 5'd16, (i == 0) ? 32'hF0 : 32'hF1);
            exp_q.push_back({5'd3, 32'h11});
            @(negedge clk);
            n_cmp++;
            if (lu_ready !== (i < 2)) begin n_bad++; $display("FAIL rm_ready[%0d]: got %b expected %b", i, lu_ready, i < 2); end
        end
        drive(1, 5'd3, 32'h11, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rm_we_async: got %b expected 0", rf_we); end
        n_cmp++;
        if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL rm_stall_async: got %b expected 0", pipe_stall); end
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_after[%0d]: got %b expected 1", i, lu_ready); end
            n_cmp++;
            if (rf_we !== 1'b0 || pipe_stall !== 1'b0) begin n_bad++; $display("FAIL rm_flushed[%0d]: got we=%b stall=%b expected 0/0", i, rf_we, pipe_stall); end
            drive(0, 0, 0, 0, 0, 0);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL rm_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_idle_push();
        test_starve();
        test_back_to_back();
        test_x0();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency unit (multiply/divide, load-miss return) that completes out of band. Long-latency results are queued in a 2-entry buffer and written in idle write-back slots. A starvation counter freezes the pipeline for one cycle when a queued result has waited too long. Sits between the write-back select and the register file write port.

## Interface

- DATA_W, 32, register data width
- STARVE_MAX, 4, denied cycles tolerated by the buffer head before a forced pipeline stall (>=1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  pipeline write-back write enable
- wb_rd  in  5  pipeline destination register
- wb_data  in  DATA_W  pipeline write-back data
- lu_valid  in  1  long-latency result valid
- lu_rd  in  5  long-latency destination register
- lu_data  in  DATA_W  long-latency result data
- lu_ready  out  1  buffer can accept a result
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- pipe_stall  out  1  hold all pipeline stages, including MEM/WB, this cycle

## Operation

- Buffer: 2-entry FIFO of {rd, data}, with registered occupancy count 0..2.
- lu_ready = (count != 2). It depends only on registered count, so there is no push-when-full even if a pop happens in the same cycle.
- A handshake (lu_valid & lu_ready) with lu_rd == 0 completes but stores nothing.
- wb_eff = wb_we & (wb_rd != 0). Pipeline writes to x0 never reach rf_we.
- Starvation counter cnt, 0..STARVE_MAX:
  - cleared when the FIFO is empty or on a pop.
  - otherwise incremented each cycle the head is present and not granted.
  - saturates at STARVE_MAX.
- pipe_stall = (cnt == STARVE_MAX) & (count != 0). It is a function of registered state only.
- Grant per cycle, priority order:
  - pipe_stall=1: write the FIFO head and pop. wb_eff is ignored. The pipeline holds the same WB instruction and re-presents it next cycle.
  - wb_eff=1: write the pipeline value.
  - count!=0: write the FIFO head and pop.
  - else: rf_we=0.
- rf_rd/rf_wdata follow the granted source. When rf_we=0 they follow the wb inputs (don't-care).
- No bypass: a result is written at the earliest one cycle after acceptance.
- Push and pop in the same cycle are legal (count unchanged, order preserved).
- WAW between a queued result and a later pipeline write to the same rd is excluded by the issue scoreboard. This block does not check it.

## Timing

- Reset (asynchronous, immediate): count=0, cnt=0, FIFO contents discarded.
  - rf_we=0 is forced while rst_n is low.
  - pipe_stall=0, lu_ready=1.
- Reset mid-operation drops queued results. The long-latency unit is reset by the same rst_n.
- Acceptance latency: a result accepted at edge T is at the head at T+1 if the FIFO was empty. If the slot is free it is written in cycle T+1.
- Starvation bound: let E be the first cycle the head is present with cnt=0.
  - If denied in cycles E..E+STARVE_MAX-1, then cnt=STARVE_MAX in cycle E+STARVE_MAX. pipe_stall=1 and the head is written in that cycle.
  - Worst-case wait is STARVE_MAX+1 cycles. Exactly one stall cycle is used per forced write.
- After a forced pop, the next entry (if any) starts at cnt=0. pipe_stall deasserts the following cycle unless STARVE_MAX elapses again.
- pipe_stall never asserts with an empty FIFO.
- lu_ready goes 0 the cycle after the second entry is stored. It returns to 1 the cycle after a pop.

## Test plan

- Idle pipeline (wb_we=0). Push lu_rd=5, lu_data=0xDEADBEEF at edge T -> rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF in cycle T+1. No pipe_stall.
- Pipeline writes wb_rd=3, data 0x11 every cycle. Push one LU result, STARVE_MAX=4 -> pipeline writes for 4 cycles. Then pipe_stall=1 for exactly one cycle with the LU value written. The pipeline write of rd 3 follows the next cycle.
- Two pushes back-to-back with continuous pipeline writes -> lu_ready=0 after the second push. A third lu_valid is held off. Results are written in push order, each after its own STARVE_MAX wait.
- wb_we=1 with wb_rd=0 while the FIFO holds one entry -> the head is written in that cycle and rf_we never asserts for x0. A push with lu_rd=0 completes the handshake and produces no write.
- Simultaneous push and pop with count=1 -> count stays 1. The second result is written next idle cycle with the correct data.
- Assert rst_n=0 mid-cycle with count=2 and cnt=3 -> rf_we, pipe_stall drop immediately. lu_ready=1 after release. No write of the flushed entries ever occurs.
